// File: rtl/ahbl2axi_posted_bridge.sv
// AHB-Lite slave to AXI4 master bridge with posted-write FIFO and read-after-write ordering.
// Optional write-error status capture is enabled by defining AHBL2AXI_WERR_STATUS_EN.
module ahbl2axi_posted_bridge #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bus_clk_en,
  input  logic [ADDR_WIDTH-1:0] ahb_haddr,
  input  logic [2:0]            ahb_hsize,
  input  logic [1:0]            ahb_htrans,
  input  logic                  ahb_hwrite,
  input  logic                  ahb_hsel,
  input  logic                  ahb_hreadyin,
  input  logic [2:0]            ahb_hburst,
  input  logic [3:0]            ahb_hprot,
  input  logic [DATA_WIDTH-1:0] ahb_hwdata,
  output logic [DATA_WIDTH-1:0] ahb_hrdata,
  output logic                  ahb_hreadyout,
  output logic                  ahb_hresp,
  output logic [ID_WIDTH-1:0]   axi_awid,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic [7:0]            axi_awlen,
  output logic [2:0]            axi_awsize,
  output logic [1:0]            axi_awburst,
  output logic [2:0]            axi_awprot,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [DATA_WIDTH-1:0] axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                  axi_wlast,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  input  logic [ID_WIDTH-1:0]   axi_bid,
  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  output logic [ID_WIDTH-1:0]   axi_arid,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]            axi_arlen,
  output logic [2:0]            axi_arsize,
  output logic [1:0]            axi_arburst,
  output logic [2:0]            axi_arprot,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [ID_WIDTH-1:0]   axi_rid,
  input  logic [DATA_WIDTH-1:0] axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rlast,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  output logic                  wr_err,
  output logic [ADDR_WIDTH-1:0] wr_err_addr,
  input  logic                  wr_err_clr
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam int PW = $clog2(WBUF_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WDATA  = 3'd1;
  localparam logic [2:0] S_RDRAIN = 3'd2;
  localparam logic [2:0] S_RADDR  = 3'd3;
  localparam logic [2:0] S_RWAIT  = 3'd4;
  localparam logic [2:0] S_RDONE  = 3'd5;
  localparam logic [2:0] S_ERR1   = 3'd6;
  localparam logic [2:0] S_ERR2   = 3'd7;

  logic [2:0]            state_q, state_d, nxt_acc;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            size_q;
  logic [PW:0]           cnt_q, cnt_d, bcnt_q, bcnt_d;
  logic [PW-1:0]         wp_q, rp_q;
  logic                  aw_done_q, w_done_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [ADDR_WIDTH-1:0] m_addr [WBUF_DEPTH];
  logic [2:0]            m_size [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] m_data [WBUF_DEPTH];
  logic [NB-1:0]         m_strb [WBUF_DEPTH];

  logic          full, acc, inv, push, pop;
  logic          aw_hs, w_hs, b_ev, pend_d;
  logic [LB-1:0] amask;
  logic [31:0]   smask;
  logic [NB-1:0] strb;

  assign full = cnt_q == (PW+1)'(WBUF_DEPTH);

  always_comb begin
    ahb_hreadyout = 1'b1;
    ahb_hresp     = 1'b0;
    unique case (state_q)
      S_WDATA:  ahb_hreadyout = !full;
      S_RDRAIN,
      S_RADDR,
      S_RWAIT:  ahb_hreadyout = 1'b0;
      S_ERR1: begin
        ahb_hreadyout = 1'b0;
        ahb_hresp     = 1'b1;
      end
      S_ERR2:   ahb_hresp = 1'b1;
      default: ;
    endcase
  end

  assign acc = bus_clk_en & ahb_hsel & ahb_htrans[1]
             & ahb_hreadyin & ahb_hreadyout;
  assign amask = LB'((32'd1 << ahb_hsize) - 32'd1);
  assign inv = (ahb_hsize > 3'(LB))
             | (|(ahb_haddr[LB-1:0] & amask));

  assign smask = (32'd1 << (32'd1 << size_q)) - 32'd1;
  assign strb  = NB'(smask) << addr_q[LB-1:0];

  // AW is held back once WBUF_DEPTH responses are outstanding
  assign axi_awvalid = (cnt_q != '0) & !aw_done_q
                     & (bcnt_q != (PW+1)'(WBUF_DEPTH));
  assign axi_wvalid  = (cnt_q != '0) & !w_done_q;

  assign push  = bus_clk_en & (state_q == S_WDATA) & !full;
  assign aw_hs = bus_clk_en & axi_awvalid & axi_awready;
  assign w_hs  = bus_clk_en & axi_wvalid & axi_wready;
  assign b_ev  = bus_clk_en & axi_bvalid;
  assign pop   = bus_clk_en & (aw_done_q | aw_hs)
               & (w_done_q | w_hs);

  assign cnt_d  = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  assign bcnt_d = bcnt_q + (PW+1)'(aw_hs) - (PW+1)'(b_ev);
  assign pend_d = (cnt_d != '0) | (bcnt_d != '0);

  always_comb begin
    nxt_acc = S_IDLE;
    if (acc) begin
      if (inv)             nxt_acc = S_ERR1;
      else if (ahb_hwrite) nxt_acc = S_WDATA;
      else if (pend_d)     nxt_acc = S_RDRAIN;
      else                 nxt_acc = S_RADDR;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_WDATA:  if (!full) state_d = nxt_acc;
      S_RDRAIN: if (!pend_d) state_d = S_RADDR;
      S_RADDR:  if (axi_arready) state_d = S_RWAIT;
      S_RWAIT:
        if (axi_rvalid)
          state_d = (axi_rresp == 2'b00) ? S_RDONE : S_ERR1;
      S_ERR1:   state_d = S_ERR2;
      default:  state_d = nxt_acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      cnt_q     <= '0;
      bcnt_q    <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
    end else if (bus_clk_en) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bcnt_q    <= bcnt_d;
      aw_done_q <= pop ? 1'b0 : (aw_done_q | aw_hs);
      w_done_q  <= pop ? 1'b0 : (w_done_q | w_hs);
      if (acc) begin
        addr_q <= ahb_haddr;
        size_q <= ahb_hsize;
      end
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      if (state_q == S_RWAIT && axi_rvalid)
        rdata_q <= axi_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      m_addr[wp_q] <= addr_q;
      m_size[wp_q] <= size_q;
      m_data[wp_q] <= ahb_hwdata;
      m_strb[wp_q] <= strb;
    end
  end

  assign ahb_hrdata  = rdata_q;
  assign axi_awid    = '0;
  assign axi_awaddr  = m_addr[rp_q];
  assign axi_awlen   = 8'd0;
  assign axi_awsize  = m_size[rp_q];
  assign axi_awburst = 2'b01;
  assign axi_awprot  = 3'b000;
  assign axi_wdata   = m_data[rp_q];
  assign axi_wstrb   = m_strb[rp_q];
  assign axi_wlast   = 1'b1;
  assign axi_bready  = 1'b1;
  assign axi_arid    = '0;
  assign axi_araddr  = addr_q;
  assign axi_arlen   = 8'd0;
  assign axi_arsize  = size_q;
  assign axi_arburst = 2'b01;
  assign axi_arprot  = 3'b000;
  assign axi_arvalid = state_q == S_RADDR;
  assign axi_rready  = 1'b1;

`ifdef AHBL2AXI_WERR_STATUS_EN
  // B responses return in AW order, so this queue names each one
  logic [ADDR_WIDTH-1:0] eq_mem [WBUF_DEPTH];
  logic [PW-1:0]         eq_wp_q, eq_rp_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] err_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      eq_wp_q    <= '0;
      eq_rp_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (bus_clk_en) begin
      if (aw_hs) eq_wp_q <= eq_wp_q + 1'b1;
      if (b_ev)  eq_rp_q <= eq_rp_q + 1'b1;
      if (wr_err_clr) begin
        err_q      <= 1'b0;
        err_addr_q <= '0;
      end else if (b_ev && axi_bresp != 2'b00) begin
        err_q <= 1'b1;
        if (!err_q) err_addr_q <= eq_mem[eq_rp_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) eq_mem[eq_wp_q] <= axi_awaddr;
  end

  assign wr_err      = err_q;
  assign wr_err_addr = err_addr_q;

  logic unused_in;
  assign unused_in = ^{ahb_hburst, ahb_hprot, axi_bid,
                       axi_rid, axi_rlast};
`else
  assign wr_err      = 1'b0;
  assign wr_err_addr = '0;

  logic unused_in;
  assign unused_in = ^{ahb_hburst, ahb_hprot, axi_bid,
                       axi_rid, axi_rlast, axi_bresp,
                       wr_err_clr};
`endif

endmodule

// File: tb/tb_ahbl2axi_posted_bridge.sv
// Directed bench for ahbl2axi_posted_bridge: AHB-side tasks, simple AXI slave.
// Write-error status checks follow AHBL2AXI_WERR_STATUS_EN.
module tb_ahbl2axi_posted_bridge;
  localparam int AW = 32;
  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en;
  logic [AW-1:0] ahb_haddr;
  logic [2:0] ahb_hsize, ahb_hburst;
  logic [1:0] ahb_htrans;
  logic ahb_hwrite, ahb_hsel, ahb_hreadyin;
  logic [3:0] ahb_hprot;
  logic [DW-1:0] ahb_hwdata, ahb_hrdata;
  logic ahb_hreadyout, ahb_hresp;
  logic [0:0] axi_awid, axi_bid, axi_arid, axi_rid;
  logic [AW-1:0] axi_awaddr, axi_araddr;
  logic [7:0] axi_awlen, axi_arlen, axi_wstrb;
  logic [2:0] axi_awsize, axi_awprot;
  logic [2:0] axi_arsize, axi_arprot;
  logic [1:0] axi_awburst, axi_arburst;
  logic [1:0] axi_bresp, axi_rresp;
  logic axi_awvalid, axi_awready, axi_wlast;
  logic axi_wvalid, axi_wready, axi_bvalid, axi_bready;
  logic axi_arvalid, axi_arready, axi_rlast;
  logic axi_rvalid, axi_rready;
  logic [DW-1:0] axi_wdata, axi_rdata;
  logic wr_err, wr_err_clr;
  logic [AW-1:0] wr_err_addr;

  ahbl2axi_posted_bridge #(
    .ID_WIDTH(1), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .WBUF_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .bus_clk_en(en),
    .ahb_haddr(ahb_haddr), .ahb_hsize(ahb_hsize),
    .ahb_htrans(ahb_htrans), .ahb_hwrite(ahb_hwrite),
    .ahb_hsel(ahb_hsel), .ahb_hreadyin(ahb_hreadyin),
    .ahb_hburst(ahb_hburst), .ahb_hprot(ahb_hprot),
    .ahb_hwdata(ahb_hwdata), .ahb_hrdata(ahb_hrdata),
    .ahb_hreadyout(ahb_hreadyout), .ahb_hresp(ahb_hresp),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awprot(axi_awprot),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready), .axi_bid(axi_bid),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready), .axi_arid(axi_arid),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rid(axi_rid),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready), .wr_err(wr_err),
    .wr_err_addr(wr_err_addr), .wr_err_clr(wr_err_clr)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int aw_n = 0, w_n = 0, ar_n = 0, b_n = 0;
  int b_iss = 0, r_iss = 0, bwait = 0;
  int b_delay = 0;
  int ar_first = -1, b_last = -1;
  logic [1:0] bresp_cfg = 2'b00;
  logic [1:0] rresp_cfg = 2'b00;
  logic [DW-1:0] rdata_cfg = '0;
  logic [AW-1:0] awa_q[$];
  logic [2:0] aws_q[$];
  logic [DW-1:0] wd_q[$];
  logic [7:0] wst_q[$];

  // AXI-side monitor, sampled on the active edge
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (en) begin
        if (axi_awvalid && axi_awready) begin
          awa_q.push_back(axi_awaddr);
          aws_q.push_back(axi_awsize);
          aw_n++;
        end
        if (axi_wvalid && axi_wready) begin
          wd_q.push_back(axi_wdata);
          wst_q.push_back(axi_wstrb);
          w_n++;
        end
        if (axi_arvalid && axi_arready) ar_n++;
        if (axi_arvalid && ar_first < 0) ar_first = cyc;
        if (axi_bvalid) begin
          b_n++;
          b_last = cyc;
        end
      end
    end
  end

  initial begin
    axi_bvalid = 1'b0;
    axi_bresp  = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      axi_bvalid = 1'b0;
      if (aw_n > b_iss && w_n > b_iss) begin
        if (bwait < b_delay) bwait++;
        else begin
          axi_bvalid = 1'b1;
          axi_bresp  = bresp_cfg;
          b_iss++;
          bwait = 0;
        end
      end
    end
  end

  initial begin
    axi_rvalid = 1'b0;
    axi_rresp  = 2'b00;
    axi_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      axi_rvalid = 1'b0;
      if (ar_n > r_iss) begin
        axi_rvalid = 1'b1;
        axi_rresp  = rresp_cfg;
        axi_rdata  = rdata_cfg;
        r_iss++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [AW-1:0] a,
                            input logic [2:0] s,
                            input logic w);
    ahb_hsel   = 1'b1;
    ahb_htrans = 2'b10;
    ahb_haddr  = a;
    ahb_hsize  = s;
    ahb_hwrite = w;
  endtask

  task automatic idle_bus();
    ahb_hsel   = 1'b0;
    ahb_htrans = 2'b00;
  endtask

  task automatic phase(output int waits, output logic resp,
                       output logic [DW-1:0] rd);
    waits = 0;
    while (!ahb_hreadyout && waits < 100) begin
      tick();
      waits++;
    end
    resp = ahb_hresp;
    rd   = ahb_hrdata;
    checks++;
    if (waits >= 100) begin
      errors++;
      $display("FAIL phase_timeout: waited %0d, limit 100", waits);
    end
    tick();
  endtask

  task automatic do_write(input logic [AW-1:0] a,
                          input logic [2:0] s,
                          input logic [DW-1:0] d,
                          output int waits);
    int w0;
    logic r;
    logic [DW-1:0] rd;
    addr_phase(a, s, 1'b1);
    phase(w0, r, rd);
    idle_bus();
    ahb_hwdata = d;
    phase(waits, r, rd);
  endtask

  task automatic do_read(input logic [AW-1:0] a,
                         input logic [2:0] s,
                         output int waits, output logic resp,
                         output logic [DW-1:0] rd);
    int w0;
    logic r;
    logic [DW-1:0] x;
    addr_phase(a, s, 1'b0);
    phase(w0, r, x);
    idle_bus();
    phase(waits, resp, rd);
  endtask

  task automatic drain();
    int n = 0;
    while ((axi_awvalid || axi_wvalid || b_n != aw_n)
           && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain_timeout: %0d cycles, limit 300", n);
    end
    tick();
    tick();
  endtask

  task automatic clear_logs();
    awa_q.delete();
    aws_q.delete();
    wd_q.delete();
    wst_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({ahb_hreadyout, ahb_hresp} !== 2'b10) begin
      errors++;
      $display("FAIL reset_ahb: rdy/resp %b, want 10",
               {ahb_hreadyout, ahb_hresp});
    end
    checks++;
    if ({axi_awvalid, axi_wvalid, axi_arvalid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_valids: %b, want 000",
               {axi_awvalid, axi_wvalid, axi_arvalid});
    end
    checks++;
    if (ahb_hrdata !== '0 || wr_err !== 1'b0
        || wr_err_addr !== '0) begin
      errors++;
      $display("FAIL reset_regs: hrdata %h err %b addr %h, want 0",
               ahb_hrdata, wr_err, wr_err_addr);
    end
  endtask

  task automatic test_byte_write();
    int w;
    clear_logs();
    do_write(32'h1005, 3'd0, 64'h0000_A500_0000_0000, w);
    checks++;
    if (w !== 0) begin
      errors++;
      $display("FAIL byte_wait: %0d wait states, want 0", w);
    end
    checks++;
    if ({axi_awvalid, axi_wvalid} !== 2'b11) begin
      errors++;
      $display("FAIL byte_aw_t2: aw/w valid %b, want 11",
               {axi_awvalid, axi_wvalid});
    end
    drain();
    checks++;
    if (awa_q.size() != 1 || wst_q.size() != 1) begin
      errors++;
      $display("FAIL byte_count: aw %0d w %0d, want 1 1",
               awa_q.size(), wst_q.size());
    end else if (awa_q[0] !== 32'h1005 || aws_q[0] !== 3'd0
                 || wst_q[0] !== 8'h20
                 || wd_q[0] !== 64'h0000_A500_0000_0000) begin
      errors++;
      $display("FAIL byte_fields: addr %h size %0d strb %h data %h, want 1005 0 20 0000a50000000000",
               awa_q[0], aws_q[0], wst_q[0], wd_q[0]);
    end
  endtask

  task automatic test_strobe();
    logic [AW-1:0] ta [3] = '{32'h8, 32'h6, 32'h24};
    logic [2:0] ts [3] = '{3'd3, 3'd1, 3'd2};
    logic [7:0] te [3] = '{8'hFF, 8'hC0, 8'hF0};
    int w;
    for (int i = 0; i < 3; i++) begin
      clear_logs();
      do_write(ta[i], ts[i], 64'h0123_4567_89AB_CDEF, w);
      drain();
      checks++;
      if (awa_q.size() != 1 || wst_q.size() != 1) begin
        errors++;
        $display("FAIL strobe_count[%0d]: aw %0d, want 1",
                 i, awa_q.size());
      end else if (wst_q[0] !== te[i] || awa_q[0] !== ta[i]
                   || aws_q[0] !== ts[i]) begin
        errors++;
        $display("FAIL strobe[%0d]: strb %h addr %h size %0d, want %h %h %0d",
                 i, wst_q[0], awa_q[0], aws_q[0],
                 te[i], ta[i], ts[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int wt [5];
    logic r;
    logic [DW-1:0] rd;
    logic [DW-1:0] d;
    int w0;
    int aw_at_done;
    clear_logs();
    axi_awready = 1'b0;
    addr_phase(32'h100, 3'd2, 1'b1);
    phase(w0, r, rd);
    fork
      begin
        repeat (10) @(posedge clk);
        #1 axi_awready = 1'b1;
      end
    join_none
    for (int i = 0; i < 5; i++) begin
      ahb_hwdata = {32'hA0 + 32'(i), 32'hB0 + 32'(i)};
      if (i < 4) addr_phase(32'h100 + 32'(4*(i+1)), 3'd2, 1'b1);
      else idle_bus();
      phase(wt[i], r, rd);
      if (i == 4) aw_at_done = awa_q.size();
    end
    checks++;
    if (wt[0] != 0 || wt[1] != 0 || wt[2] != 0 || wt[3] != 0) begin
      errors++;
      $display("FAIL b2b_first4: waits %0d %0d %0d %0d, want 0",
               wt[0], wt[1], wt[2], wt[3]);
    end
    checks++;
    if (wt[4] == 0 || aw_at_done < 1) begin
      errors++;
      $display("FAIL b2b_fifth: waits %0d aw %0d, want >0 and >=1",
               wt[4], aw_at_done);
    end
    drain();
    checks++;
    if (awa_q.size() != 5 || wst_q.size() != 5) begin
      errors++;
      $display("FAIL b2b_count: aw %0d w %0d, want 5",
               awa_q.size(), wst_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        d = {32'hA0 + 32'(i), 32'hB0 + 32'(i)};
        checks++;
        if (awa_q[i] !== 32'h100 + 32'(4*i) || wd_q[i] !== d
            || wst_q[i] !== ((i % 2) ? 8'hF0 : 8'h0F)) begin
          errors++;
          $display("FAIL b2b_order[%0d]: addr %h data %h strb %h",
                   i, awa_q[i], wd_q[i], wst_q[i]);
        end
      end
    end
  endtask

  task automatic test_raw();
    int w;
    logic r;
    logic [DW-1:0] rd;
    b_delay = 10;
    b_last = -1;
    ar_first = -1;
    do_write(32'h2000, 3'd2, 64'h0000_0000_1234_5678, w);
    rdata_cfg = 64'h0000_0000_DEAD_BEEF;
    do_read(32'h2000, 3'd2, w, r, rd);
    b_delay = 0;
    checks++;
    if (b_last < 0 || ar_first <= b_last) begin
      errors++;
      $display("FAIL raw_order: arvalid at %0d, bvalid at %0d, want ar after b",
               ar_first, b_last);
    end
    checks++;
    if (rd !== 64'h0000_0000_DEAD_BEEF || r !== 1'b0) begin
      errors++;
      $display("FAIL raw_data: hrdata %h resp %b, want deadbeef 0",
               rd, r);
    end
    drain();
  endtask

  task automatic test_read_basic();
    int w, w0;
    logic r;
    logic [DW-1:0] rd;
    rdata_cfg = 64'h0123_4567_89AB_CDEF;
    addr_phase(32'h18, 3'd3, 1'b0);
    phase(w0, r, rd);
    idle_bus();
    checks++;
    if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h18
        || axi_arsize !== 3'd3) begin
      errors++;
      $display("FAIL rd_ar_t1: arvalid %b addr %h size %0d, want 1 18 3",
               axi_arvalid, axi_araddr, axi_arsize);
    end
    phase(w, r, rd);
    checks++;
    if (w != 2 || rd !== 64'h0123_4567_89AB_CDEF || r !== 1'b0) begin
      errors++;
      $display("FAIL rd_basic: waits %0d data %h resp %b, want 2 0123456789abcdef 0",
               w, rd, r);
    end
  endtask

  task automatic test_error_resp();
    int w0, ar0, aw0;
    logic r;
    logic [DW-1:0] rd;
    ar0 = ar_n;
    aw0 = aw_n;
    addr_phase(32'h3001, 3'd1, 1'b0);
    phase(w0, r, rd);
    idle_bus();
    checks++;
    if ({ahb_hresp, ahb_hreadyout, axi_arvalid} !== 3'b100) begin
      errors++;
      $display("FAIL err_c1: resp/rdy/arvalid %b, want 100",
               {ahb_hresp, ahb_hreadyout, axi_arvalid});
    end
    tick();
    checks++;
    if ({ahb_hresp, ahb_hreadyout} !== 2'b11) begin
      errors++;
      $display("FAIL err_c2: resp/rdy %b, want 11",
               {ahb_hresp, ahb_hreadyout});
    end
    tick();
    checks++;
    if ({ahb_hresp, ahb_hreadyout} !== 2'b01) begin
      errors++;
      $display("FAIL err_after: resp/rdy %b, want 01",
               {ahb_hresp, ahb_hreadyout});
    end
    addr_phase(32'h20, 3'd4, 1'b1);
    phase(w0, r, rd);
    idle_bus();
    checks++;
    if ({ahb_hresp, ahb_hreadyout} !== 2'b10) begin
      errors++;
      $display("FAIL err_size_c1: resp/rdy %b, want 10",
               {ahb_hresp, ahb_hreadyout});
    end
    tick();
    tick();
    drain();
    checks++;
    if (ar_n != ar0 || aw_n != aw0) begin
      errors++;
      $display("FAIL err_no_axi: ar %0d aw %0d, want %0d %0d",
               ar_n, aw_n, ar0, aw0);
    end
  endtask

  task automatic test_rd_slverr();
    int w, n;
    logic r;
    logic [DW-1:0] rd;
    rresp_cfg = 2'b10;
    addr_phase(32'h40, 3'd3, 1'b0);
    phase(w, r, rd);
    idle_bus();
    n = 0;
    while (!ahb_hresp && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if ({ahb_hresp, ahb_hreadyout} !== 2'b10) begin
      errors++;
      $display("FAIL rerr_c1: resp/rdy %b, want 10",
               {ahb_hresp, ahb_hreadyout});
    end
    tick();
    checks++;
    if ({ahb_hresp, ahb_hreadyout} !== 2'b11) begin
      errors++;
      $display("FAIL rerr_c2: resp/rdy %b, want 11",
               {ahb_hresp, ahb_hreadyout});
    end
    tick();
    rresp_cfg = 2'b00;
    rdata_cfg = 64'h5555_AAAA_1234_0042;
    do_read(32'h48, 3'd3, w, r, rd);
    checks++;
    if (rd !== 64'h5555_AAAA_1234_0042 || r !== 1'b0) begin
      errors++;
      $display("FAIL rerr_next: data %h resp %b, want 5555aaaa12340042 0",
               rd, r);
    end
  endtask

  task automatic test_clk_en();
    int w, aw0;
    clear_logs();
    axi_awready = 1'b0;
    do_write(32'h50, 3'd3, 64'hFEED_0000_0000_BEEF, w);
    aw0 = aw_n;
    en = 1'b0;
    axi_awready = 1'b1;
    repeat (3) tick();
    checks++;
    if (axi_awvalid !== 1'b1 || aw_n != aw0
        || ahb_hreadyout !== 1'b1) begin
      errors++;
      $display("FAIL clken_hold: awvalid %b aw %0d rdy %b, want 1 %0d 1",
               axi_awvalid, aw_n, ahb_hreadyout, aw0);
    end
    en = 1'b1;
    drain();
    checks++;
    if (awa_q.size() != 1 || awa_q[0] !== 32'h50) begin
      errors++;
      $display("FAIL clken_resume: aw count %0d, want 1 at 50",
               awa_q.size());
    end
  endtask

  task automatic test_wr_err();
    int w;
    bresp_cfg = 2'b10;
    do_write(32'h4000, 3'd2, 64'h1, w);
    drain();
`ifdef AHBL2AXI_WERR_STATUS_EN
    checks++;
    if (wr_err !== 1'b1 || wr_err_addr !== 32'h4000) begin
      errors++;
      $display("FAIL werr_set: err %b addr %h, want 1 4000",
               wr_err, wr_err_addr);
    end
    do_write(32'h4010, 3'd2, 64'h2, w);
    drain();
    checks++;
    if (wr_err !== 1'b1 || wr_err_addr !== 32'h4000) begin
      errors++;
      $display("FAIL werr_keep: err %b addr %h, want 1 4000",
               wr_err, wr_err_addr);
    end
    wr_err_clr = 1'b1;
    tick();
    wr_err_clr = 1'b0;
    checks++;
    if (wr_err !== 1'b0 || wr_err_addr !== '0) begin
      errors++;
      $display("FAIL werr_clr: err %b addr %h, want 0 0",
               wr_err, wr_err_addr);
    end
`else
    checks++;
    if (wr_err !== 1'b0 || wr_err_addr !== '0) begin
      errors++;
      $display("FAIL werr_off: err %b addr %h, want 0 0",
               wr_err, wr_err_addr);
    end
`endif
    bresp_cfg = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b1;
    ahb_haddr = '0;
    ahb_hsize = '0;
    ahb_htrans = 2'b00;
    ahb_hwrite = 1'b0;
    ahb_hsel = 1'b0;
    ahb_hreadyin = 1'b1;
    ahb_hburst = '0;
    ahb_hprot = '0;
    ahb_hwdata = '0;
    axi_awready = 1'b1;
    axi_wready = 1'b1;
    axi_arready = 1'b1;
    axi_bid = '0;
    axi_rid = '0;
    axi_rlast = 1'b1;
    wr_err_clr = 1'b0;
    test_reset();
    test_byte_write();
    test_strobe();
    test_back_to_back();
    test_raw();
    test_read_basic();
    test_error_resp();
    test_rd_slverr();
    test_clk_en();
    test_wr_err();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
